// File: rtl/axi_lite_master12.sv
// AXI4-Lite initiator moving 12-bit words between PL request logic and AXI slaves.
// One transaction outstanding; strobe/busy request side, one-cycle done pulse.
module axi_lite_master12 #(
    parameter logic [31:0] BASEADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        req_strobe,
    input  logic        req_write,
    input  logic [14:0] req_addr,
    input  logic [11:0] req_wdata,
    output logic        req_busy,
    output logic        rsp_done,
    output logic [11:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] maxi_ARADDR,
    output logic        maxi_ARVALID,
    input  logic        maxi_ARREADY,
    input  logic [31:0] maxi_RDATA,
    input  logic [1:0]  maxi_RRESP,
    input  logic        maxi_RVALID,
    output logic        maxi_RREADY,
    output logic [31:0] maxi_AWADDR,
    output logic        maxi_AWVALID,
    input  logic        maxi_AWREADY,
    output logic [31:0] maxi_WDATA,
    output logic [3:0]  maxi_WSTRB,
    output logic        maxi_WVALID,
    input  logic        maxi_WREADY,
    input  logic [1:0]  maxi_BRESP,
    input  logic        maxi_BVALID,
    output logic        maxi_BREADY,
    output logic [2:0]  maxi_ARPROT,
    output logic [2:0]  maxi_AWPROT
);

    localparam int CW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    state_t        state;
    logic [31:0]   addr_q;
    logic [11:0]   wdata_q;
    logic [CW-1:0] stall;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic b_hs;
    logic r_hs;
    logic aw_ok;
    logic w_ok;
    logic ar_ok;
    logic any_hs;
    logic unused_rdata;

    assign maxi_ARADDR = addr_q;
    assign maxi_AWADDR = addr_q;
    assign maxi_WDATA  = {20'b0, wdata_q};
    assign maxi_WSTRB  = 4'b1111;
    assign maxi_ARPROT = 3'b000;
    assign maxi_AWPROT = 3'b000;

    assign unused_rdata = ^maxi_RDATA[31:12];

    assign aw_hs = maxi_AWVALID & maxi_AWREADY;
    assign w_hs  = maxi_WVALID & maxi_WREADY;
    assign ar_hs = maxi_ARVALID & maxi_ARREADY;

    // A channel counts as finished if it already dropped VALID or completes now
    assign aw_ok = ~maxi_AWVALID | maxi_AWREADY;
    assign w_ok  = ~maxi_WVALID | maxi_WREADY;
    assign ar_ok = ~maxi_ARVALID | maxi_ARREADY;

    assign b_hs = maxi_BVALID & maxi_BREADY & aw_ok & w_ok;
    assign r_hs = maxi_RVALID & maxi_RREADY & ar_ok;

    assign any_hs = aw_hs | w_hs | ar_hs | b_hs | r_hs;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            stall        <= '0;
            req_busy     <= 1'b0;
            rsp_done     <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_timeout  <= 1'b0;
            maxi_ARVALID <= 1'b0;
            maxi_RREADY  <= 1'b0;
            maxi_AWVALID <= 1'b0;
            maxi_WVALID  <= 1'b0;
            maxi_BREADY  <= 1'b0;
        end else begin
            rsp_done <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req_strobe) begin
                        addr_q   <= BASEADDR + {15'b0, req_addr, 2'b00};
                        wdata_q  <= req_wdata;
                        req_busy <= 1'b1;
                        if (req_write) begin
                            maxi_AWVALID <= 1'b1;
                            maxi_WVALID  <= 1'b1;
                            maxi_BREADY  <= 1'b1;
                            state        <= WRITE;
                        end else begin
                            maxi_ARVALID <= 1'b1;
                            maxi_RREADY  <= 1'b1;
                            state        <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (aw_hs) maxi_AWVALID <= 1'b0;
                    if (w_hs)  maxi_WVALID  <= 1'b0;
                    if (b_hs) begin
                        maxi_BREADY <= 1'b0;
                        rsp_err     <= (maxi_BRESP != 2'b00);
                        rsp_done    <= 1'b1;
                        req_busy    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                READ: begin
                    if (ar_hs) maxi_ARVALID <= 1'b0;
                    if (r_hs) begin
                        maxi_RREADY <= 1'b0;
                        rsp_rdata   <= maxi_RDATA[11:0];
                        rsp_err     <= (maxi_RRESP != 2'b00);
                        rsp_done    <= 1'b1;
                        req_busy    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Stall watchdog only flags; the transaction is never abandoned
            if (state == IDLE || any_hs) begin
                stall <= '0;
            end else if (stall != TMAX) begin
                stall <= stall + 1'b1;
                if (TIMEOUT != 0 && stall + 1'b1 == TMAX) rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master12.sv
// Randomized scoreboard bench for axi_lite_master12 with a behavioural AXI slave.
// Expectations come from a word-addressed reference memory kept in the bench.
module tb_axi_lite_master12;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int TMO = 8;

    logic        CLOCK;
    logic        RESET_N;
    logic        req_strobe;
    logic        req_write;
    logic [14:0] req_addr;
    logic [11:0] req_wdata;
    logic        req_busy;
    logic        rsp_done;
    logic [11:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [2:0]  ARPROT;
    logic [2:0]  AWPROT;

    axi_lite_master12 #(
        .BASEADDR(BASE),
        .TIMEOUT (TMO)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .req_strobe  (req_strobe),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_busy    (req_busy),
        .rsp_done    (rsp_done),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .maxi_ARADDR (ARADDR),
        .maxi_ARVALID(ARVALID),
        .maxi_ARREADY(ARREADY),
        .maxi_RDATA  (RDATA),
        .maxi_RRESP  (RRESP),
        .maxi_RVALID (RVALID),
        .maxi_RREADY (RREADY),
        .maxi_AWADDR (AWADDR),
        .maxi_AWVALID(AWVALID),
        .maxi_AWREADY(AWREADY),
        .maxi_WDATA  (WDATA),
        .maxi_WSTRB  (WSTRB),
        .maxi_WVALID (WVALID),
        .maxi_WREADY (WREADY),
        .maxi_BRESP  (BRESP),
        .maxi_BVALID (BVALID),
        .maxi_BREADY (BREADY),
        .maxi_ARPROT (ARPROT),
        .maxi_AWPROT (AWPROT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_edge = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [11:0] data;
    } req_t;

    typedef struct {
        logic [11:0] rdata;
        logic        err;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    logic [11:0] ref_mem [logic [14:0]];
    logic [11:0] last_rdata = '0;

    // Slave behaviour knobs for the current transaction
    int          aw_d, w_d, ar_d, b_d, r_d;
    logic [1:0]  resp;
    logic [19:0] rhi;
    bit          use_rd;
    logic [31:0] rd_val;

    bit          aw_got, w_got, ar_got;
    int          aw_c, w_c, ar_c, b_c, r_c;
    logic [31:0] cap_awaddr;
    logic [31:0] cap_araddr;
    logic [11:0] cap_wdata;
    logic [11:0] smem [logic [31:0]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual event required none", name);
    endtask

    task automatic slave_clear();
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    endtask

    // Handshake capture and address-side scoreboard checks
    always @(posedge CLOCK) begin
        cyc++;
        if (!RESET_N) begin
            slave_clear();
        end else begin
            if (AWVALID && AWREADY) begin
                if (aw_got || req_q.size() == 0) bad("aw_extra");
                else begin
                    chk("aw_is_write", 32'(req_q[0].wr), 1);
                    chk("awaddr", AWADDR, req_q[0].addr);
                    chk("awprot", 32'(AWPROT), 0);
                end
                aw_got = 1;
                cap_awaddr = AWADDR;
            end
            if (WVALID && WREADY) begin
                if (w_got || req_q.size() == 0) bad("w_extra");
                else begin
                    chk("wdata", WDATA, {20'b0, req_q[0].data});
                    chk("wstrb", 32'(WSTRB), 32'hF);
                end
                w_got = 1;
                cap_wdata = WDATA[11:0];
            end
            if (ARVALID && ARREADY) begin
                if (ar_got || req_q.size() == 0) bad("ar_extra");
                else begin
                    chk("ar_is_read", 32'(req_q[0].wr), 0);
                    chk("araddr", ARADDR, req_q[0].addr);
                    chk("arprot", 32'(ARPROT), 0);
                end
                ar_got = 1;
                cap_araddr = ARADDR;
            end
            if (BVALID && BREADY) begin
                smem[cap_awaddr] = cap_wdata;
                if (req_q.size() != 0) void'(req_q.pop_front());
                slave_clear();
            end
            if (RVALID && RREADY) begin
                if (req_q.size() != 0) void'(req_q.pop_front());
                slave_clear();
            end
        end
    end

    // Slave drive, away from the active edge
    always @(negedge CLOCK) begin
        if (!RESET_N) begin
            AWREADY = 0; WREADY = 0; ARREADY = 0;
            BVALID = 0; RVALID = 0;
        end else begin
            AWREADY = 0;
            if (AWVALID && !aw_got) begin
                if (aw_c >= aw_d) AWREADY = 1;
                aw_c++;
            end
            WREADY = 0;
            if (WVALID && !w_got) begin
                if (w_c >= w_d) WREADY = 1;
                w_c++;
            end
            ARREADY = 0;
            if (ARVALID && !ar_got) begin
                if (ar_c >= ar_d) ARREADY = 1;
                ar_c++;
            end
            BVALID = 0;
            if (aw_got && w_got) begin
                if (b_c >= b_d) begin
                    BVALID = 1;
                    BRESP = resp;
                end
                b_c++;
            end
            RVALID = 0;
            if (ar_got) begin
                if (r_c >= r_d) begin
                    RVALID = 1;
                    RRESP = resp;
                    if (use_rd) RDATA = rd_val;
                    else RDATA = {rhi, smem.exists(cap_araddr) ?
                                       smem[cap_araddr] : 12'h000};
                end
                r_c++;
            end
        end
    end

    // Response monitor
    always @(negedge CLOCK) begin
        if (RESET_N && rsp_done) begin
            if (rsp_q.size() == 0) bad("done_extra");
            else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("busy_at_done", 32'(req_busy), 0);
            end
        end
        if (RESET_N && WVALID && req_q.size() != 0 && req_q[0].wr)
            chk("wdata_stable", WDATA, {20'b0, req_q[0].data});
    end

    task automatic set_cfg(input int a, input int w, input int ar,
                           input int b, input int r, input logic [1:0] rs);
        aw_d = a; w_d = w; ar_d = ar; b_d = b; r_d = r;
        resp = rs;
        rhi = 20'($urandom);
        use_rd = 0;
    endtask

    task automatic issue(input bit wr, input logic [14:0] a,
                         input logic [11:0] d);
        int n;
        logic [11:0] rd;
        n = 0;
        while (req_busy && n < 500) begin
            @(negedge CLOCK);
            n++;
        end
        if (req_busy) bad("busy_stuck");
        req_q.push_back('{wr, BASE + {15'b0, a, 2'b00}, d});
        if (wr) begin
            ref_mem[a] = d;
            rsp_q.push_back('{last_rdata, resp != 2'b00});
        end else begin
            if (use_rd) rd = rd_val[11:0];
            else rd = ref_mem.exists(a) ? ref_mem[a] : 12'h000;
            last_rdata = rd;
            rsp_q.push_back('{rd, resp != 2'b00});
        end
        req_write = wr;
        req_addr = a;
        req_wdata = d;
        req_strobe = 1;
        strobe_edge = cyc + 1;
        @(negedge CLOCK);
        req_strobe = 0;
    endtask

    task automatic wait_done(output int lat);
        int n;
        n = 0;
        do begin
            @(negedge CLOCK);
            n++;
        end while (!rsp_done && n < 300);
        if (!rsp_done) bad("done_wait_expired");
        lat = cyc - strobe_edge;
    endtask

    task automatic chk_idle(input string name);
        chk(name, 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY,
                       req_busy, rsp_done, rsp_err, rsp_timeout}), 0);
        chk({name, "_rdata"}, 32'(rsp_rdata), 0);
    endtask

    logic [14:0] a_tab [8];

    initial begin
        int lat;
        a_tab = '{15'h0000, 15'h0001, 15'h0002, 15'h0003,
                  15'h7FFF, 15'h7FFE, 15'h0100, 15'h4000};
        RESET_N = 0;
        req_strobe = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        ARREADY = 0; AWREADY = 0; WREADY = 0;
        RVALID = 0; BVALID = 0; RDATA = '0; RRESP = '0; BRESP = '0;
        set_cfg(0, 0, 0, 0, 0, 2'b00);
        slave_clear();
        repeat (3) @(negedge CLOCK);
        chk_idle("reset_state");
        RESET_N = 1;
        @(negedge CLOCK);

        // Fast write, latency 2
        set_cfg(0, 0, 0, 0, 0, 2'b00);
        issue(1, 15'h0001, 12'o7654);
        wait_done(lat);
        chk("write_latency", 32'(lat), 2);

        // WREADY lags AWREADY
        set_cfg(0, 6, 0, 0, 0, 2'b00);
        issue(1, 15'h0002, 12'h5A5);
        repeat (3) @(negedge CLOCK);
        chk("awvalid_dropped", 32'(AWVALID), 0);
        chk("wvalid_held", 32'(WVALID), 1);
        wait_done(lat);

        // Slow read with SLVERR, top address wraps past 2^32
        set_cfg(0, 0, 0, 0, 4, 2'b10);
        use_rd = 1;
        rd_val = 32'hFFFF_F123;
        issue(0, 15'h7FFF, 12'h000);
        repeat (3) @(negedge CLOCK);
        chk("busy_during_read", 32'(req_busy), 1);
        wait_done(lat);

        // Read back earlier writes, fast slave
        set_cfg(0, 0, 0, 0, 0, 2'b00);
        issue(0, 15'h0001, 12'h000);
        wait_done(lat);
        chk("read_latency", 32'(lat), 2);

        // Strobe while busy is ignored, follow-up on cycle after done
        set_cfg(0, 0, 0, 0, 4, 2'b00);
        issue(0, 15'h0002, 12'h000);
        req_write = 1; req_addr = 15'h0005; req_wdata = 12'hBAD;
        req_strobe = 1;
        @(negedge CLOCK);
        req_strobe = 0;
        wait_done(lat);
        set_cfg(0, 0, 0, 0, 0, 2'b01);
        issue(0, 15'h0001, 12'h000);
        wait_done(lat);
        chk("back_to_back_latency", 32'(lat), 2);

        // Randomized traffic with short stalls
        for (int i = 0; i < 60; i++) begin
            logic [1:0] rs;
            rs = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), rs);
            repeat ($urandom_range(0, 2)) @(negedge CLOCK);
            issue($urandom_range(0, 1) == 1, a_tab[$urandom_range(0, 7)],
                  12'($urandom));
            wait_done(lat);
        end
        chk("no_timeout_yet", 32'(rsp_timeout), 0);

        // ARREADY held off beyond the stall limit
        set_cfg(0, 0, 20, 0, 0, 2'b00);
        issue(0, 15'h7FFE, 12'h000);
        repeat (4) @(negedge CLOCK);
        chk("timeout_early", 32'(rsp_timeout), 0);
        repeat (8) @(negedge CLOCK);
        chk("timeout_set", 32'(rsp_timeout), 1);
        chk("arvalid_waiting", 32'(ARVALID), 1);
        wait_done(lat);
        set_cfg(0, 0, 0, 0, 0, 2'b00);
        issue(1, 15'h0003, 12'h3C3);
        wait_done(lat);
        chk("timeout_sticky", 32'(rsp_timeout), 1);

        // Reset while W is pending
        set_cfg(0, 50, 0, 0, 0, 2'b00);
        issue(1, 15'h1234, 12'h777);
        repeat (3) @(negedge CLOCK);
        chk("w_pending", 32'(WVALID), 1);
        RESET_N = 0;
        @(negedge CLOCK);
        chk_idle("mid_reset");
        RESET_N = 1;
        req_q.delete();
        rsp_q.delete();
        ref_mem.delete(15'h1234);
        last_rdata = '0;
        @(negedge CLOCK);
        set_cfg(1, 0, 1, 0, 2, 2'b00);
        issue(0, 15'h0003, 12'h000);
        wait_done(lat);
        chk("post_reset_rdata", 32'(rsp_rdata), 32'h3C3);
        repeat (3) @(negedge CLOCK);
        chk("queues_drained", 32'(req_q.size() + rsp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual running required finished");
        $fatal(1);
    end

endmodule
